// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl opcodes, handshake FSM states and
// the iterative-unit operation select. Imported by the execute unit, its
// iterative mul/div helper and the ALU decoder.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } alu_state_e;

  typedef enum logic {
    MD_MUL,
    MD_DIV
  } md_op_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply (shift-add) / unsigned divide (restoring), one step per
// clock for WIDTH clocks after start.
//   clk_i, rst_i  clock, async active-high reset
//   start_i       load operands and begin (a_i/b_i: mcand/mplier or dividend/divisor)
//   op_i          MD_MUL or MD_DIV
//   done_o        high during the cycle whose edge performs the last step
//   result_o      value after the current step (product low bits or quotient);
//                 once idle it holds the final value
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  // MUL: acc = product, opb = multiplicand (<<), sh = multiplier (>>)
  // DIV: acc = remainder, opb = divisor, sh = dividend shifting into quotient
  logic [WIDTH-1:0] acc_q, acc_d, opb_q, opb_d, sh_q, sh_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  md_op_e           op_q, op_d;
  logic [WIDTH:0]   trial, diff;

  always_comb begin
    acc_d  = acc_q;
    opb_d  = opb_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    op_d   = op_q;
    done_o = busy_q && (cnt_q == LAST);
    trial  = {acc_q, sh_q[WIDTH-1]};
    diff   = trial - {1'b0, opb_q};
    if (start_i) begin
      op_d   = op_i;
      acc_d  = '0;
      opb_d  = (op_i == MD_MUL) ? a_i : b_i;
      sh_d   = (op_i == MD_MUL) ? b_i : a_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (op_q == MD_MUL) begin
        if (sh_q[0]) acc_d = acc_q + opb_q;
        opb_d = opb_q << 1;
        sh_d  = sh_q >> 1;
      end else if (trial >= {1'b0, opb_q}) begin
        // remainder < divisor keeps the difference within WIDTH bits
        acc_d = diff[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = trial[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + SHW'(1);
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
    result_o = (op_q == MD_MUL) ? acc_d : sh_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opb_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      op_q   <= MD_MUL;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      op_q   <= op_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides.
//   clk, reset           clock, async active-high reset
//   valid_in/ready_out   upstream handshake (ALUControl, SrcA, SrcB)
//   valid_out/ready_in   downstream handshake (ALUResult, Zero, illegal)
// Single-cycle ops and divide special cases answer one cycle after accept;
// MUL takes WIDTH more cycles, DIV WIDTH+1 more (sign fix-up cycle).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_e       state_q;
  logic [WIDTH-1:0] res_q, sc_res, mag_a, mag_b, md_a, md_b, md_res, fix_res;
  logic             valid_q, zero_q, ill_q, neg_q, sc_ill;
  logic             accept, is_mul, div_iter, md_start, md_done;
  logic [SHW-1:0]   shamt;
  md_op_e           md_op;

  // DONE is included so a consumed result can overlap the next accept.
  assign ready_out = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                     (!valid_q || ready_in);
  assign accept    = valid_in && ready_out;
  assign is_mul    = (ALUControl == ALU_MUL);
  assign div_iter  = (ALUControl == ALU_DIV) && (SrcB != '0) &&
                     !((SrcA == MOST_NEG) && (SrcB == '1));
  assign shamt     = SrcB[SHW-1:0];
  assign mag_a     = SrcA[WIDTH-1] ? ('0 - SrcA) : SrcA;
  assign mag_b     = SrcB[WIDTH-1] ? ('0 - SrcB) : SrcB;
  assign md_start  = accept && (is_mul || div_iter);
  assign md_op     = is_mul ? MD_MUL : MD_DIV;
  assign md_a      = is_mul ? SrcA : mag_a;
  assign md_b      = is_mul ? SrcB : mag_b;
  assign fix_res   = neg_q ? ('0 - md_res) : md_res;

  // One-cycle results, including the two divide cases needing no iteration.
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (ALUControl)
      ALU_ADD: sc_res = SrcA + SrcB;
      ALU_SUB: sc_res = SrcA - SrcB;
      ALU_AND: sc_res = SrcA & SrcB;
      ALU_OR:  sc_res = SrcA | SrcB;
      ALU_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SRA: sc_res = $signed(SrcA) >>> shamt;
      ALU_SRL: sc_res = SrcA >> shamt;
      ALU_SLL: sc_res = SrcA << shamt;
      ALU_DIV: sc_res = (SrcB == '0) ? '1 : MOST_NEG;
      ALU_MUL: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i    (clk),
    .rst_i    (reset),
    .start_i  (md_start),
    .op_i     (md_op),
    .a_i      (md_a),
    .b_i      (md_b),
    .done_o   (md_done),
    .result_o (md_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Result consumed: clear so nothing stale lingers on the bus.
          if (valid_q && ready_in) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
          if (accept) begin
            if (is_mul) begin
              state_q <= ST_MUL;
            end else if (div_iter) begin
              state_q <= ST_DIV;
              neg_q   <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
            end else begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
              res_q   <= sc_res;
              zero_q  <= (sc_res == '0);
              ill_q   <= sc_ill;
            end
          end
        end
        ST_MUL: if (md_done) begin
          state_q <= ST_DONE;
          valid_q <= 1'b1;
          res_q   <= md_res;
          zero_q  <= (md_res == '0);
          ill_q   <= 1'b0;
        end
        ST_DIV: if (md_done) state_q <= ST_FIX;
        ST_FIX: begin
          state_q <= ST_DONE;
          valid_q <= 1'b1;
          res_q   <= fix_res;
          zero_q  <= (fix_res == '0);
          ill_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign valid_out = valid_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors with literal expectations plus a
// per-cycle monitor comparing handshake and results to an arithmetic model.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset, valid_in, ready_in;
  logic        ready_out, valid_out, Zero, illegal;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA, SrcB, ALUResult;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          due;
  } exp_t;
  exp_t exp_q[$];
  bit   head_seen = 1'b0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .valid_out(valid_out), .ready_in(ready_in),
    .ALUResult(ALUResult), .Zero(Zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Arithmetic reference: {illegal, result}
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        il;
    r  = '0;
    il = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = $signed(a) >>> b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: r = a << b[4:0];
      4'd9: r = a * b;
      4'd4: begin
        if (b == 32'd0)                              r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else                                         r = $signed(a) / $signed(b);
      end
      default: il = 1'b1;
    endcase
    return {il, r};
  endfunction

  function automatic int lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'd9) return 33;
    if (op == 4'd4 && b != 0 && !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 34;
    return 1;
  endfunction

  // Monitor: ready_out every cycle, result/timing whenever valid_out is high.
  always @(negedge clk) begin
    logic        mrdy;
    logic [32:0] m;
    if (reset) begin
      exp_q.delete();
      head_seen = 1'b0;
    end else begin
      if (exp_q.size() == 0)          mrdy = 1'b1;
      else if (cyc >= exp_q[0].due)   mrdy = ready_in;
      else                            mrdy = 1'b0;
      chk("mon ready_out", {31'd0, ready_out}, {31'd0, mrdy});
      if (valid_out) begin
        if (exp_q.size() == 0) chk("mon unexpected valid_out", 32'd1, 32'd0);
        else begin
          chk("mon ALUResult", ALUResult, exp_q[0].res);
          chk("mon Zero", {31'd0, Zero}, {31'd0, exp_q[0].res == 32'd0});
          chk("mon illegal", {31'd0, illegal}, {31'd0, exp_q[0].ill});
          if (!head_seen) chk("mon valid cycle", cyc, exp_q[0].due);
          head_seen = 1'b1;
        end
      end else if (exp_q.size() != 0 && cyc == exp_q[0].due) begin
        chk("mon valid_out missing", 32'd0, 32'd1);
      end
      if (valid_out && ready_in && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        head_seen = 1'b0;
      end
      if (valid_in && ready_out) begin
        m = model(ALUControl, SrcA, SrcB);
        exp_q.push_back('{res: m[31:0], ill: m[32], due: cyc + lat(ALUControl, SrcA, SrcB)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    ALUControl = op; SrcA = a; SrcB = b; valid_in = 1'b1;
    while (!ready_out && n < 200) begin tick(); n++; end
    chk("issue ready_out", {31'd0, ready_out}, 32'd1);
    tick();
    valid_in = 1'b0;
    ALUControl = 4'hA; SrcA = $urandom; SrcB = $urandom;  // captured operands must not matter now
  endtask

  task automatic run(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ez, input logic ei, input int elat);
    int n = 0;
    int rdy_hi = 0;
    issue(op, a, b);
    while (!valid_out && n < 200) begin
      if (ready_out) rdy_hi++;
      tick();
      n++;
    end
    chk({nm, " latency"}, n + 1, elat);
    chk({nm, " result"}, ALUResult, er);
    chk({nm, " Zero"}, {31'd0, Zero}, {31'd0, ez});
    chk({nm, " illegal"}, {31'd0, illegal}, {31'd0, ei});
    chk({nm, " ready_out while busy"}, rdy_hi, 0);
    ready_in = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    ALUControl = 4'd0; SrcA = '0; SrcB = '0;
    repeat (2) tick();
    chk("reset valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset ALUResult", ALUResult, 32'd0);
    chk("reset Zero", {31'd0, Zero}, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post-reset ready_out", {31'd0, ready_out}, 32'd1);
    tick();

    run("add",  4'd0, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    run("sub",  4'd1, 32'd7, 32'd7,         32'd0,         1'b1, 1'b0, 1);
    run("and",  4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1);
    run("or",   4'd3, 32'hF000_0001, 32'h0000_0100, 32'hF000_0101, 1'b0, 1'b0, 1);
    run("sra",  4'd6, 32'h8000_0000, 32'd4,  32'hF800_0000, 1'b0, 1'b0, 1);
    run("srl",  4'd7, 32'h8000_0000, 32'd36, 32'h0800_0000, 1'b0, 1'b0, 1);
    run("sll",  4'd8, 32'd1, 32'd33, 32'd2, 1'b0, 1'b0, 1);
    run("slt",  4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    run("slt2", 4'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1);
    ready_in = 1'b0;  // result must still appear while downstream stalls
    run("mul",  4'd9, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 1'b0, 33);
    run("mul0", 4'd9, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, 33);
    run("div",  4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, 34);
    run("div+", 4'd4, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 34);
    run("divn", 4'd4, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 1'b0, 34);
    run("div0", 4'd4, 32'd10, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    run("divo", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1);
    run("ill",  4'hA, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1);

    // Backpressure then back-to-back accept of an illegal code
    ready_in = 1'b0;
    issue(4'd0, 32'd3, 32'd4);
    ALUControl = 4'hF; SrcA = 32'd9; SrcB = 32'd9; valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp ALUResult held", ALUResult, 32'd7);
      chk("bp valid_out held", {31'd0, valid_out}, 32'd1);
      chk("bp ready_out low", {31'd0, ready_out}, 32'd0);
      tick();
    end
    ready_in = 1'b1;
    #1;
    chk("bp ready_out release", {31'd0, ready_out}, 32'd1);
    tick();
    valid_in = 1'b0;
    chk("b2b valid_out", {31'd0, valid_out}, 32'd1);
    chk("b2b ALUResult", ALUResult, 32'd0);
    chk("b2b illegal", {31'd0, illegal}, 32'd1);
    chk("b2b Zero", {31'd0, Zero}, 32'd1);
    tick();

    // Reset in the middle of a divide
    issue(4'd4, 32'd1000, 32'd3);
    repeat (9) tick();
    reset = 1'b1;
    #1;
    chk("midrst valid_out", {31'd0, valid_out}, 32'd0);
    chk("midrst ALUResult", ALUResult, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("midrst ready_out", {31'd0, ready_out}, 32'd1);
    repeat (40) tick();  // monitor flags any stale valid_out here
    run("after rst", 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
